// File: rtl/hazard_control_unit.sv
// Pipeline interlock for the NARK datapath: tracks E/M/W destination tags and drives stall, flush and forwarding.
// Define HAZARD_FWD_EN to enable operand forwarding; otherwise dependents stall until the producer retires.
module hazard_control_unit #(
   parameter int unsigned NREGS  = 16,
   parameter int unsigned PC_REG = 15
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ValidD,
   input  logic [$clog2(NREGS)-1:0] RA1D,
   input  logic [$clog2(NREGS)-1:0] RA2D,
   input  logic                     Use1D,
   input  logic                     Use2D,
   input  logic [$clog2(NREGS)-1:0] WA4D,
   input  logic                     RegWriteD,
   input  logic                     MemToRegD,
   input  logic                     BranchTakenE,
   input  logic                     MemReadyM,
   output logic                     StallF,
   output logic                     StallD,
   output logic                     StallE,
   output logic                     StallM,
   output logic                     FlushD,
   output logic                     FlushE,
   output logic [1:0]               FwdAE,
   output logic [1:0]               FwdBE
);
   localparam int unsigned TW = $clog2(NREGS);
   localparam logic [TW-1:0] PC_TAG = TW'(PC_REG);

   typedef struct packed {
      logic          valid;
      logic [TW-1:0] dest;
      logic          regwrite;
      logic          load;
   } slot_t;

   typedef struct packed {
      logic          valid;
      logic [TW-1:0] dest;
      logic          regwrite;
   } wslot_t;

   slot_t  slot_e, slot_m;
   wslot_t slot_w;

   logic rd1_d, rd2_d;
   logic match_e, match_m, match_w;
   logic freeze, flush, hazard, stall_d;

   function automatic logic hit(input logic valid, input logic regwrite,
                                input logic [TW-1:0] dest,
                                input logic [TW-1:0] tag, input logic used);
      return used && (tag != PC_TAG) && valid && regwrite && (dest == tag);
   endfunction

   assign rd1_d = ValidD & Use1D;
   assign rd2_d = ValidD & Use2D;

   assign match_e = hit(slot_e.valid, slot_e.regwrite, slot_e.dest, RA1D, rd1_d)
                  | hit(slot_e.valid, slot_e.regwrite, slot_e.dest, RA2D, rd2_d);
   assign match_m = hit(slot_m.valid, slot_m.regwrite, slot_m.dest, RA1D, rd1_d)
                  | hit(slot_m.valid, slot_m.regwrite, slot_m.dest, RA2D, rd2_d);
   assign match_w = hit(slot_w.valid, slot_w.regwrite, slot_w.dest, RA1D, rd1_d)
                  | hit(slot_w.valid, slot_w.regwrite, slot_w.dest, RA2D, rd2_d);

   // Freeze outranks flush: E is held, so BranchTakenE persists and the flush fires once M completes.
   assign freeze = slot_m.valid & slot_m.load & ~MemReadyM;
   assign flush  = BranchTakenE & ~freeze;

`ifdef HAZARD_FWD_EN
   logic [TW-1:0] src1_e, src2_e;
   logic          use1_e, use2_e;

   function automatic logic [1:0] fwd_sel(input logic [TW-1:0] tag, input logic used);
      if (hit(slot_m.valid, slot_m.regwrite, slot_m.dest, tag, used))
         return 2'b10;
      else if (hit(slot_w.valid, slot_w.regwrite, slot_w.dest, tag, used))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign hazard = (match_e & slot_e.load) | match_w;

   always_comb begin
      FwdAE = fwd_sel(src1_e, use1_e & slot_e.valid);
      FwdBE = fwd_sel(src2_e, use2_e & slot_e.valid);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         src1_e <= '0;
         src2_e <= '0;
         use1_e <= 1'b0;
         use2_e <= 1'b0;
      end else if (!freeze) begin
         if (flush | hazard) begin
            src1_e <= '0;
            src2_e <= '0;
            use1_e <= 1'b0;
            use2_e <= 1'b0;
         end else begin
            src1_e <= RA1D;
            src2_e <= RA2D;
            use1_e <= rd1_d;
            use2_e <= rd2_d;
         end
      end
   end
`else
   assign hazard = match_e | match_m | match_w;
   assign FwdAE  = '0;
   assign FwdBE  = '0;
`endif

   // A taken branch squashes D, which also cancels any interlock it raised.
   assign stall_d = freeze | (hazard & ~flush);

   assign StallF = stall_d;
   assign StallD = stall_d;
   assign StallE = freeze;
   assign StallM = freeze;
   assign FlushD = flush;
   assign FlushE = flush | (hazard & ~freeze);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         slot_e <= '0;
         slot_m <= '0;
         slot_w <= '0;
      end else if (freeze) begin
         slot_w <= '0;
      end else begin
         slot_w <= '{valid: slot_m.valid, dest: slot_m.dest, regwrite: slot_m.regwrite};
         slot_m <= slot_e;
         if (flush | hazard)
            slot_e <= '0;
         else
            slot_e <= '{valid: ValidD, dest: WA4D, regwrite: RegWriteD, load: MemToRegD};
      end
   end
endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vector tables, a reset corner sequence and a random run vs a reference model.
module tb_hazard_control_unit;
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic       ValidD, Use1D, Use2D, RegWriteD, MemToRegD, BranchTakenE, MemReadyM;
   logic [3:0] RA1D, RA2D, WA4D;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic [1:0] FwdAE, FwdBE;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   hazard_control_unit #(.NREGS(16), .PC_REG(15)) dut (
      .CLK(CLK), .RST(RST), .ValidD(ValidD), .RA1D(RA1D), .RA2D(RA2D),
      .Use1D(Use1D), .Use2D(Use2D), .WA4D(WA4D), .RegWriteD(RegWriteD),
      .MemToRegD(MemToRegD), .BranchTakenE(BranchTakenE), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FwdAE(FwdAE), .FwdBE(FwdBE)
   );

   always #5 CLK = ~CLK;

   // Output vector layout: {StallF, StallD, StallE, StallM, FlushD, FlushE, FwdAE, FwdBE}
   typedef struct {
      logic       v;
      logic [3:0] a1, a2;
      logic       u1, u2;
      logic [3:0] wa;
      logic       rw, ld, br, rdy;
      logic [9:0] exp;
   } vec_t;

   typedef struct {
      logic       v;
      logic [3:0] dest, s1, s2;
      logic       rw, ld, u1, u2;
   } ins_t;

   vec_t tbl[$];
   ins_t pipe[1:3];   // instructions ahead of decode: 1 = execute, 2 = memory, 3 = writeback

   function automatic vec_t mk(logic v, logic [3:0] a1, logic [3:0] a2, logic u1, logic u2,
                               logic [3:0] wa, logic rw, logic ld, logic br, logic rdy,
                               logic [9:0] exp);
      vec_t r;
      r.v = v; r.a1 = a1; r.a2 = a2; r.u1 = u1; r.u2 = u2; r.wa = wa;
      r.rw = rw; r.ld = ld; r.br = br; r.rdy = rdy; r.exp = exp;
      return r;
   endfunction

   function automatic logic [9:0] outs();
      return {StallF, StallD, StallE, StallM, FlushD, FlushE, FwdAE, FwdBE};
   endfunction

   task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t r);
      ValidD = r.v; RA1D = r.a1; RA2D = r.a2; Use1D = r.u1; Use2D = r.u2;
      WA4D = r.wa; RegWriteD = r.rw; MemToRegD = r.ld;
      BranchTakenE = r.br; MemReadyM = r.rdy;
   endtask

   function automatic logic produces(ins_t p, logic [3:0] r);
      return p.v && p.rw && (p.dest == r);
   endfunction

   // Forward code from distance: the nearest producer ahead of E wins (M -> 10, W -> 01).
   function automatic logic [1:0] fwd_code(logic [3:0] s, logic u);
      logic [1:0] code;
      code = 2'b00;
      if (FWD && pipe[1].v && u && s != 4'd15)
         for (int d = 3; d >= 2; d--)
            if (produces(pipe[d], s)) code = 2'(4 - d);
      return code;
   endfunction

   function automatic logic [9:0] model_out();
      logic       frz, fl, hz, sd, fe;
      logic [3:0] s;
      logic       u;
      frz = pipe[2].v && pipe[2].ld && !MemReadyM;
      fl  = BranchTakenE && !frz;
      hz  = 1'b0;
      for (int d = 1; d <= 3; d++)
         for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? RA1D : RA2D;
            u = (k == 0) ? Use1D : Use2D;
            if (ValidD && u && s != 4'd15 && produces(pipe[d], s))
               hz |= FWD ? ((d == 1 && pipe[1].ld) || d == 3) : 1'b1;
         end
      sd = frz | (hz & !fl);
      fe = fl | (hz & !frz);
      return {sd, sd, frz, frz, fl, fe, fwd_code(pipe[1].s1, pipe[1].u1),
              fwd_code(pipe[1].s2, pipe[1].u2)};
   endfunction

   task automatic model_step(input logic [9:0] e);
      ins_t d;
      d = '{v: ValidD, dest: WA4D, s1: RA1D, s2: RA2D, rw: RegWriteD, ld: MemToRegD,
            u1: Use1D & ValidD, u2: Use2D & ValidD};
      if (e[7]) begin
         pipe[3] = '{default: '0};
      end else begin
         pipe[3] = pipe[2];
         pipe[2] = pipe[1];
         pipe[1] = e[4] ? '{default: '0} : d;
      end
   endtask

   task automatic model_clear();
      for (int i = 1; i <= 3; i++) pipe[i] = '{default: '0};
   endtask

   initial begin
      vec_t idle;
      logic [9:0] e;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      RST = 1'b0;
      drive(idle);
      #1 check("reset_outputs", outs(), 10'b0);

`ifdef HAZARD_FWD_EN
      tbl.push_back(mk(1, 0, 1, 1, 1, 2, 1, 0, 0, 1, 10'b0000000000)); // ADD r2
      tbl.push_back(mk(1, 2, 3, 1, 1, 4, 1, 0, 0, 1, 10'b0000000000)); // SUB r4 <- r2: no stall
      tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 1, 10'b0000001000)); // SUB in E: FwdA=10
      tbl.push_back(mk(1, 2, 0, 1, 1, 6, 1, 0, 0, 1, 10'b1100010001)); // D-vs-W stall, AND in E FwdB=01
      tbl.push_back(mk(1, 2, 0, 1, 1, 6, 1, 0, 0, 1, 10'b0000000000)); // retired: proceeds
      tbl.push_back(mk(1, 1, 0, 1, 0, 15, 1, 0, 0, 1, 10'b0000000000)); // writes r15
      tbl.push_back(mk(1, 15, 6, 1, 0, 3, 1, 1, 0, 1, 10'b0000000000)); // LD r3, r15 src / unused r6
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 0, 1, 10'b1100010000)); // load-use
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 0, 0, 10'b1111000000)); // freeze 1
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 1, 0, 10'b1111000000)); // freeze 2, branch deferred
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 1, 0, 10'b1111000000)); // freeze 3
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 1, 1, 10'b0000110000)); // release: flush pulse
      tbl.push_back(mk(0, 3, 1, 1, 1, 7, 1, 0, 0, 1, 10'b0000000000)); // squashed slot
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 0, 1, 10'b0000000000));
`else
      tbl.push_back(mk(1, 0, 1, 1, 1, 2, 1, 0, 0, 1, 10'b0000000000)); // ADD r2
      tbl.push_back(mk(1, 2, 3, 1, 1, 15, 1, 0, 0, 1, 10'b1100010000)); // SUB r2: stall 1 (E)
      tbl.push_back(mk(1, 2, 3, 1, 1, 15, 1, 0, 0, 1, 10'b1100010000)); // stall 2 (M)
      tbl.push_back(mk(1, 2, 3, 1, 1, 15, 1, 0, 0, 1, 10'b1100010000)); // stall 3 (W)
      tbl.push_back(mk(1, 2, 3, 1, 1, 15, 1, 0, 0, 1, 10'b0000000000)); // proceeds
      tbl.push_back(mk(1, 15, 0, 1, 0, 3, 1, 1, 0, 1, 10'b0000000000)); // r15 src, producer r15
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 0, 1, 10'b1100010000)); // load-use
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 0, 0, 10'b1111000000)); // freeze 1
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 1, 0, 10'b1111000000)); // freeze 2, branch deferred
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 1, 0, 10'b1111000000)); // freeze 3
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 1, 1, 10'b0000110000)); // flush cancels stall
      tbl.push_back(mk(0, 3, 1, 1, 1, 7, 1, 0, 0, 1, 10'b0000000000)); // squashed slot
      tbl.push_back(mk(1, 3, 1, 1, 1, 7, 1, 0, 0, 1, 10'b0000000000));
`endif

      @(negedge CLK);
      RST = 1'b1;
      foreach (tbl[i]) begin
         @(negedge CLK);
         drive(tbl[i]);
         #2 check($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

      // Reset asserted during a load-use stall clears everything at once.
      @(negedge CLK);
      drive(idle);
      @(negedge CLK);
      drive(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 1, 0));
      #2 check("rst_seq_load", outs(), 10'b0);
      @(negedge CLK);
      drive(mk(1, 3, 1, 1, 1, 7, 1, 0, 0, 1, 0));
      #2 check("rst_seq_stall", outs(), 10'b1100010000);
      RST = 1'b0;
      #1 check("rst_async_clear", outs(), 10'b0);
      @(negedge CLK);
      RST = 1'b1;
      #2 check("post_reset_no_hazard", outs(), 10'b0);

      @(negedge CLK);
      drive(idle);
      RST = 1'b0;
      #2 RST = 1'b1;
      model_clear();

      for (int n = 0; n < 600; n++) begin
         vec_t r;
         logic [3:0] t[3];
         @(negedge CLK);
         for (int k = 0; k < 3; k++) begin
            t[k] = 4'($urandom_range(0, 4));
            if (t[k] == 4'd4) t[k] = 4'd15;
         end
         r = mk($urandom_range(0, 3) != 0, t[0], t[1], $urandom_range(0, 4) != 0,
                $urandom_range(0, 4) != 0, t[2], $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) != 0, 10'b0);
         drive(r);
         #2;
         e = model_out();
         check($sformatf("rand%0d", n), outs(), e);
         model_step(e);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
